config_mem_shadow: RTL and testbench
====================================

Name: config_mem_shadow

Overview:
- Parametrised, clocked successor to the per-tile frame-latch configuration memory.
- Captures frames into a shadow array through the existing FrameData/FrameStrobe interface, and transfers them atomically to the active ConfigBits on a commit request.
- Adds frame readback over a valid/ack handshake, a written-frame bitmap, strobe-error detection, and an emulation preload.
- Instantiated once per tile; its outputs drive the tile's switch-matrix and BEL configuration inputs.

Parameters:
- MaxFramesPerCol, 20, number of FrameStrobe lines.
- FrameBitsPerRow, 32, width of FrameData and of one frame.
- NoConfigBits, 640, number of config bits held. Must satisfy 1 <= NoConfigBits <= MaxFramesPerCol*FrameBitsPerRow.
- SHADOW_ENABLE, 1. 1 = writes go to shadow and reach active only on commit. 0 = writes go directly to active.
- EMULATION_ENABLE, 0. 1 = reset preloads EMULATION_CONFIG and frame writes are ignored.
- EMULATION_CONFIG, 0, NoConfigBits-wide preload value.

Ports:
- CLK  in  1  configuration clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- FrameData  in  FrameBitsPerRow  frame payload.
- FrameStrobe  in  MaxFramesPerCol  one-hot frame select, sampled each cycle.
- CommitReq  in  1  single-cycle commit request.
- CommitDone  out  1  one-cycle pulse acknowledging a commit.
- RbReq  in  1  readback request.
- RbFrame  in  clog2(MaxFramesPerCol)  frame index to read back.
- RbAck  in  1  consumer accepts RbData.
- RbValid  out  1  RbData is valid.
- RbData  out  FrameBitsPerRow  readback frame contents.
- FramesWritten  out  MaxFramesPerCol  bitmap of frames written since the last commit or reset.
- AllWritten  out  1  every used frame has its bitmap bit set.
- StrobeErr  out  1  sticky flag: more than one strobe bit was seen.
- ConfigBits  out  NoConfigBits  active configuration.
- ConfigBits_N  out  NoConfigBits  always the bitwise inverse of ConfigBits.

Behaviour:
- Definitions:
  - NumFrames = ceil(NoConfigBits / FrameBitsPerRow).
  - Config bit k maps to frame k / FrameBitsPerRow, bit k % FrameBitsPerRow.
  - Frame bits beyond NoConfigBits are discarded on write and read back as 0.
- Reset (asynchronous):
  - Shadow and active = 0, or EMULATION_CONFIG when EMULATION_ENABLE = 1. ConfigBits_N follows as the inverse.
  - CommitDone = 0, RbValid = 0, RbData = 0, FramesWritten = 0, StrobeErr = 0.
  - Readback state returns to IDLE; any in-flight readback is dropped.
- Write:
  - Condition: FrameStrobe has exactly one bit f set, f < NumFrames, and EMULATION_ENABLE = 0.
  - Action: frame f is written with FrameData (to shadow, or to active when SHADOW_ENABLE = 0), and FramesWritten[f] is set.
  - f >= NumFrames: ignored, no error.
  - FrameStrobe all zero: no action.
- Multiple strobe bits set in one cycle: no write, StrobeErr is set and held until reset.
- Emulation mode: all writes are ignored and FramesWritten stays 0. Strobe error detection still operates.
- Commit, on a cycle with CommitReq = 1:
  - SHADOW_ENABLE = 1: active <= shadow at the next edge, visible on ConfigBits one cycle after the request edge.
  - FramesWritten is cleared.
  - CommitDone pulses high for exactly one cycle in the cycle after the request.
  - SHADOW_ENABLE = 0: only the FramesWritten clear and the CommitDone pulse occur.
  - CommitReq held high for several cycles: commits every cycle, one CommitDone pulse per cycle.
- Write and commit in the same cycle:
  - Commit copies the pre-write shadow.
  - The write lands in shadow.
  - FramesWritten afterwards contains only bit f.
- AllWritten = AND of FramesWritten[NumFrames-1:0]. It is combinational from the registered bitmap.
- Readback FSM (reads the active array):
  - IDLE: RbReq = 1 latches RbFrame. Next cycle moves to VALID, with RbData = active frame (0 if RbFrame >= NumFrames) and RbValid = 1.
  - VALID: RbData is held stable. RbReq is ignored. On RbAck = 1, RbValid falls next cycle and the FSM returns to IDLE.
  - A new request may be accepted in the cycle after the return to IDLE (one-cycle bubble minimum).
  - A commit during VALID does not alter the held RbData.
- Latency:
  - Write to shadow: 1 cycle.
  - Commit to ConfigBits: 1 cycle.
  - Readback request to RbValid: 1 cycle.

Test Plan:
- Reset with EMULATION_ENABLE = 0 -> ConfigBits = 0, ConfigBits_N all ones, RbValid = 0. With EMULATION_ENABLE = 1 and EMULATION_CONFIG = 640'hA5.. -> ConfigBits equals the preload after reset, and a strobe write leaves it unchanged.
- SHADOW_ENABLE = 1: write frame 3 = 32'hDEADBEEF -> ConfigBits unchanged and FramesWritten = 0x8. Pulse CommitReq -> next cycle ConfigBits[127:96] = DEADBEEF, CommitDone for one cycle, FramesWritten = 0.
- Write all 20 frames -> AllWritten = 1 after the 20th edge. Strobe 0x3 -> no write, StrobeErr = 1, still set after 10 idle cycles.
- Write frame 5 and pulse CommitReq in the same cycle -> active frame 5 holds the old shadow value, FramesWritten = 0x20. A second commit -> the new frame 5 value appears on ConfigBits.
- Readback frame 3 -> RbValid one cycle after the request, with DEADBEEF. Hold RbAck = 0 for 5 cycles -> data stable and a new RbReq ignored. RbAck -> RbValid low next cycle. Readback frame 25 -> RbData = 0.
- Assert RST while RbValid = 1 and shadow is partially written -> outputs immediately return to their reset values with no clock edge.

Source files
------------

// File: rtl/config_mem_shadow.sv
// Per-tile configuration memory: frames land in a shadow array and move to the active bits on
// commit, with handshaked frame readback, a written-frame bitmap and strobe-error detection.
module config_mem_shadow #(
    parameter int unsigned                 MaxFramesPerCol  = 20,
    parameter int unsigned                 FrameBitsPerRow  = 32,
    parameter int unsigned                 NoConfigBits     = 640,
    parameter bit                          SHADOW_ENABLE    = 1'b1,
    parameter bit                          EMULATION_ENABLE = 1'b0,
    parameter logic [NoConfigBits-1:0]     EMULATION_CONFIG = '0,
    localparam int unsigned                IdxW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic                       CommitReq,
    output logic                       CommitDone,
    input  logic                       RbReq,
    input  logic [IdxW-1:0]            RbFrame,
    input  logic                       RbAck,
    output logic                       RbValid,
    output logic [FrameBitsPerRow-1:0] RbData,
    output logic [MaxFramesPerCol-1:0] FramesWritten,
    output logic                       AllWritten,
    output logic                       StrobeErr,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N
);

    localparam int unsigned NumFrames = (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow;
    localparam logic [NoConfigBits-1:0] ResetVal = EMULATION_ENABLE ? EMULATION_CONFIG : '0;

    typedef enum logic {StIdle, StValid} rb_state_e;

    logic [NoConfigBits-1:0]    r_shadow, r_active;
    logic [NoConfigBits-1:0]    w_shadow_d, w_active_d;
    logic [MaxFramesPerCol-1:0] r_fw, w_fw_d;
    logic                       r_strobe_err;
    logic                       r_commit_done;
    logic [FrameBitsPerRow-1:0] r_rb_data, w_rb_frame;
    rb_state_e                  r_rb_state, w_rb_state_d;
    logic                       w_rb_load;
    logic [IdxW-1:0]            w_wr_idx;
    logic                       w_any, w_multi, w_wr_en;

    // Bits of the addressed frame that lie beyond NoConfigBits have no storage and drop out here.
    function automatic logic [NoConfigBits-1:0] put_frame(input logic [NoConfigBits-1:0]    i_base,
                                                          input logic [IdxW-1:0]            i_idx,
                                                          input logic [FrameBitsPerRow-1:0] i_data);
        logic [NoConfigBits-1:0] v_res;
        v_res = i_base;
        for (int unsigned k = 0; k < NoConfigBits; k++) begin
            if (k / FrameBitsPerRow == 32'(i_idx)) v_res[k] = i_data[k % FrameBitsPerRow];
        end
        return v_res;
    endfunction

    always_comb begin
        w_wr_idx = '0;
        for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
            if (FrameStrobe[f]) w_wr_idx = IdxW'(f);
        end
    end

    assign w_any   = |FrameStrobe;
    assign w_multi = $countones(FrameStrobe) > 1;
    assign w_wr_en = w_any && !w_multi && (32'(w_wr_idx) < NumFrames) && !EMULATION_ENABLE;

    always_comb begin
        w_shadow_d = w_wr_en ? put_frame(r_shadow, w_wr_idx, FrameData) : r_shadow;
        w_active_d = r_active;
        if (SHADOW_ENABLE) begin
            // Commit takes the shadow as it stood before any write in the same cycle.
            if (CommitReq) w_active_d = r_shadow;
        end else if (w_wr_en) begin
            w_active_d = put_frame(r_active, w_wr_idx, FrameData);
        end
        w_fw_d = CommitReq ? '0 : r_fw;
        if (w_wr_en) w_fw_d[w_wr_idx] = 1'b1;
    end

    always_comb begin
        w_rb_frame = '0;
        for (int unsigned k = 0; k < NoConfigBits; k++) begin
            if (k / FrameBitsPerRow == 32'(RbFrame)) w_rb_frame[k % FrameBitsPerRow] = r_active[k];
        end
    end

    always_comb begin
        w_rb_state_d = r_rb_state;
        w_rb_load    = 1'b0;
        case (r_rb_state)
            StIdle: begin
                if (RbReq) begin
                    w_rb_state_d = StValid;
                    w_rb_load    = 1'b1;
                end
            end
            StValid: begin
                if (RbAck) w_rb_state_d = StIdle;
            end
            default: w_rb_state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shadow      <= ResetVal;
            r_active      <= ResetVal;
            r_fw          <= '0;
            r_strobe_err  <= 1'b0;
            r_commit_done <= 1'b0;
            r_rb_data     <= '0;
            r_rb_state    <= StIdle;
        end else begin
            r_shadow      <= w_shadow_d;
            r_active      <= w_active_d;
            r_fw          <= w_fw_d;
            r_strobe_err  <= r_strobe_err | w_multi;
            r_commit_done <= CommitReq;
            r_rb_state    <= w_rb_state_d;
            if (w_rb_load) r_rb_data <= w_rb_frame;
        end
    end

    assign CommitDone    = r_commit_done;
    assign RbValid       = (r_rb_state == StValid);
    assign RbData        = r_rb_data;
    assign FramesWritten = r_fw;
    assign AllWritten    = &r_fw[NumFrames-1:0];
    assign StrobeErr     = r_strobe_err;
    assign ConfigBits    = r_active;
    assign ConfigBits_N  = ~r_active;

endmodule

// File: tb/tb_config_mem_shadow.sv
// Scoreboard bench for config_mem_shadow: commit and readback results are queued at stimulus
// time and popped by a monitor when the DUT presents CommitDone or a new RbValid.
module tb_config_mem_shadow;

    localparam logic [639:0] EmuCfg = {80{8'hA5}};

    logic         CLK = 1'b0;
    logic         RST;
    logic [31:0]  FrameData;
    logic [19:0]  FrameStrobe;
    logic         CommitReq, RbReq, RbAck;
    logic [4:0]   RbFrame;

    logic         CommitDone, RbValid, AllWritten, StrobeErr;
    logic [31:0]  RbData;
    logic [19:0]  FramesWritten;
    logic [639:0] ConfigBits, ConfigBits_N;

    logic         e_CommitDone, e_RbValid, e_AllWritten, e_StrobeErr;
    logic [31:0]  e_RbData;
    logic [19:0]  e_FramesWritten;
    logic [639:0] e_ConfigBits, e_ConfigBits_N;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]  rb_q[$];
    logic [639:0] cm_q[$];
    logic [639:0] exp_shadow, exp_active;
    logic [19:0]  exp_fw;
    logic         rb_prev = 1'b0;

    always #5 CLK = ~CLK;

    config_mem_shadow dut (
        .CLK(CLK), .RST(RST), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .CommitReq(CommitReq), .CommitDone(CommitDone), .RbReq(RbReq), .RbFrame(RbFrame),
        .RbAck(RbAck), .RbValid(RbValid), .RbData(RbData), .FramesWritten(FramesWritten),
        .AllWritten(AllWritten), .StrobeErr(StrobeErr), .ConfigBits(ConfigBits),
        .ConfigBits_N(ConfigBits_N)
    );

    config_mem_shadow #(.EMULATION_ENABLE(1'b1), .EMULATION_CONFIG(EmuCfg)) dut_emu (
        .CLK(CLK), .RST(RST), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .CommitReq(CommitReq), .CommitDone(e_CommitDone), .RbReq(RbReq), .RbFrame(RbFrame),
        .RbAck(RbAck), .RbValid(e_RbValid), .RbData(e_RbData), .FramesWritten(e_FramesWritten),
        .AllWritten(e_AllWritten), .StrobeErr(e_StrobeErr), .ConfigBits(e_ConfigBits),
        .ConfigBits_N(e_ConfigBits_N)
    );

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int f, input logic [31:0] d, input logic commit);
        FrameStrobe    = '0;
        FrameStrobe[f] = 1'b1;
        FrameData      = d;
        CommitReq      = commit;
        if (commit) begin
            cm_q.push_back(exp_shadow);
            exp_active = exp_shadow;
            exp_fw     = '0;
        end
        exp_shadow[f*32 +: 32] = d;
        exp_fw[f]              = 1'b1;
        tick();
        FrameStrobe = '0;
        CommitReq   = 1'b0;
    endtask

    task automatic commit();
        CommitReq = 1'b1;
        cm_q.push_back(exp_shadow);
        exp_active = exp_shadow;
        exp_fw     = '0;
        tick();
        CommitReq = 1'b0;
    endtask

    task automatic rb_request(input logic [4:0] idx, input logic [31:0] exp);
        RbFrame = idx;
        RbReq   = 1'b1;
        rb_q.push_back(exp);
        tick();
        RbReq = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    initial begin
        logic [639:0] m_cfg;
        logic [31:0]  m_rb;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (CommitDone) begin
                    if (cm_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL commit_pulse: got CommitDone=1 expected no pulse");
                    end else begin
                        m_cfg = cm_q.pop_front();
                        chk("commit_cfg", ConfigBits, m_cfg);
                    end
                end
                if (RbValid && !rb_prev) begin
                    if (rb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rb_present: got RbValid=1 expected no readback");
                    end else begin
                        m_rb = rb_q.pop_front();
                        chk("rb_data", RbData, m_rb);
                    end
                end
            end
            rb_prev = RbValid;
        end
    end

    initial begin
        RST = 1'b1; FrameData = '0; FrameStrobe = '0; CommitReq = 1'b0;
        RbReq = 1'b0; RbFrame = '0; RbAck = 1'b0;
        exp_shadow = '0; exp_active = '0; exp_fw = '0;
        #12;
        chk("rst_cfg", ConfigBits, '0);
        chk("rst_cfg_n", ConfigBits_N, '1);
        chk("rst_rbvalid", RbValid, 1'b0);
        chk("rst_fw", FramesWritten, '0);
        chk("rst_strobe_err", StrobeErr, 1'b0);
        chk("emu_rst_cfg", e_ConfigBits, EmuCfg);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Shadowed write, then commit.
        wr(3, 32'hDEADBEEF, 1'b0);
        chk("shadow_hidden", ConfigBits, exp_active);
        chk("fw_frame3", FramesWritten, 20'h8);
        chk("emu_ignore_cfg", e_ConfigBits, EmuCfg);
        chk("emu_fw", e_FramesWritten, '0);
        commit();
        chk("commit_frame3", ConfigBits[127:96], 32'hDEADBEEF);
        chk("commit_cfg_n", ConfigBits_N, ~exp_active);
        chk("commit_fw_clr", FramesWritten, '0);
        chk("commitdone_hi", CommitDone, 1'b1);
        tick();
        chk("commitdone_lo", CommitDone, 1'b0);

        // Readback with a stalled consumer.
        rb_request(5'd3, 32'hDEADBEEF);
        chk("rb_latency", RbValid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            RbReq   = 1'b1;
            RbFrame = 5'd0;
            tick();
            chk("rb_hold_data", RbData, 32'hDEADBEEF);
            chk("rb_hold_valid", RbValid, 1'b1);
        end
        RbReq = 1'b0;
        RbAck = 1'b1;
        tick();
        RbAck = 1'b0;
        chk("rb_ack_drop", RbValid, 1'b0);
        rb_request(5'd25, 32'h0);
        chk("rb_oor_valid", RbValid, 1'b1);
        RbAck = 1'b1;
        tick();
        RbAck = 1'b0;

        // Fill every frame, then a multi-bit strobe.
        for (int f = 0; f < 20; f++) begin
            wr(f, 32'hA000_0000 | 32'(f), 1'b0);
            if (f == 18) chk("allwritten_lo", AllWritten, 1'b0);
        end
        chk("allwritten_hi", AllWritten, 1'b1);
        chk("fw_all", FramesWritten, exp_fw);
        chk("no_false_err", StrobeErr, 1'b0);
        FrameStrobe = 20'h3;
        FrameData   = 32'hFFFF_FFFF;
        tick();
        FrameStrobe = '0;
        chk("strobe_err", StrobeErr, 1'b1);
        chk("emu_strobe_err", e_StrobeErr, 1'b1);
        repeat (10) tick();
        chk("strobe_err_sticky", StrobeErr, 1'b1);

        // Write and commit together, then commit again on the next cycle.
        wr(5, 32'h5555_AAAA, 1'b1);
        chk("wc_frame5_old", ConfigBits[191:160], 32'hA000_0005);
        chk("wc_fw", FramesWritten, 20'h20);
        commit();
        chk("wc_frame5_new", ConfigBits[191:160], 32'h5555_AAAA);

        // Commit during a held readback, then reset mid-cycle.
        wr(7, 32'h7777_7777, 1'b0);
        rb_request(5'd7, 32'hA000_0007);
        commit();
        chk("rb_commit_stable", RbData, 32'hA000_0007);
        chk("commit_frame7", ConfigBits[255:224], 32'h7777_7777);
        wr(8, 32'h8888_8888, 1'b0);
        chk("pre_rst_valid", RbValid, 1'b1);
        #1;
        RST = 1'b1;
        #1;
        chk("arst_cfg", ConfigBits, '0);
        chk("arst_cfg_n", ConfigBits_N, '1);
        chk("arst_rbvalid", RbValid, 1'b0);
        chk("arst_rbdata", RbData, '0);
        chk("arst_fw", FramesWritten, '0);
        chk("arst_strobe_err", StrobeErr, 1'b0);
        chk("arst_allwritten", AllWritten, 1'b0);
        chk("arst_emu_cfg", e_ConfigBits, EmuCfg);
        repeat (2) tick();

        chk("rb_q_empty", 640'(rb_q.size()), '0);
        chk("cm_q_empty", 640'(cm_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
